mem_stage_sram: RTL and testbench

Memory stage of the ARM pipeline, directly downstream of the execute stage and its EXE/MEM register. It takes the ALU result as a byte address plus the store data (Rm value) and serves LDR/STR through a multi-cycle FSM on an external 16-bit asynchronous SRAM, moving each 32-bit word as two half-word accesses. While an access is in flight it deasserts `ready` so the pipeline freezes. It hands `mem_result` and the pass-through control to the MEM/WB register.

---
 rtl/mem_stage_sram_if.sv | 21 ++
 rtl/mem_stage_sram.sv | 126 ++++++++++++
 tb/tb_mem_stage_sram.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_sram_if.sv
// Pin bundle between the memory-stage controller and an external 16-bit
// asynchronous SRAM (half-word addressed, split DQ in/out with output enable).
interface mem_stage_sram_if #(
  parameter int SRAM_AW = 18
);
  logic [SRAM_AW-1:0] sram_addr;
  logic               sram_we_n;
  logic [15:0]        sram_dq_out;
  logic               sram_dq_oe;
  logic [15:0]        sram_dq_in;

  modport master (
    output sram_addr, sram_we_n, sram_dq_out, sram_dq_oe,
    input  sram_dq_in
  );

  modport slave (
    input  sram_addr, sram_we_n, sram_dq_out, sram_dq_oe,
    output sram_dq_in
  );
endinterface

// File: rtl/mem_stage_sram.sv
// ARM pipeline memory stage: serves LDR/STR as two half-word accesses on a
// 16-bit async SRAM, stalling the pipeline via ready while an access is in flight.
module mem_stage_sram #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          SRAM_AW     = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] val_rm,
  input  logic [3:0]  dest_in,
  output logic        wb_en,
  output logic        mem_r_en,
  output logic [31:0] alu_result_out,
  output logic [3:0]  dest,
  output logic [31:0] mem_result,
  output logic        ready,
  mem_stage_sram_if.master sram
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic               is_wr_q;
  logic [15:0]        lo_buf_q;
  logic [31:0]        offs;
  logic [SRAM_AW-2:0] word;
  logic               req, wr_req, last;
  logic               offs_unused;

  assign wb_en          = wb_en_in;
  assign mem_r_en       = mem_r_en_in;
  assign alu_result_out = alu_result;
  assign dest           = dest_in;

  assign req    = mem_r_en_in | mem_w_en_in;
  // A request with both enables set is treated as a read.
  assign wr_req = mem_w_en_in & ~mem_r_en_in;
  assign offs   = alu_result - BASE_ADDR;
  assign word   = offs[SRAM_AW:2];
  assign last   = (cnt_q == CW'(WAIT_CYCLES - 1));
  assign offs_unused = ^{offs[31:SRAM_AW+1], offs[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        ready = ~req;
        if (req) state_d = LOW;
      end
      LOW:  if (last) state_d = HIGH;
      HIGH: if (last) state_d = DONE;
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!rst) ready = 1'b1;
  end

  // SRAM pins are registered so they only move on the rising edge; each
  // phase holds them for WAIT_CYCLES cycles and samples DQ on its last cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q            <= '0;
      is_wr_q          <= 1'b0;
      lo_buf_q         <= '0;
      mem_result       <= '0;
      sram.sram_addr   <= '0;
      sram.sram_we_n   <= 1'b1;
      sram.sram_dq_out <= '0;
      sram.sram_dq_oe  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            cnt_q          <= '0;
            is_wr_q        <= wr_req;
            sram.sram_addr <= {word, 1'b0};
            if (wr_req) begin
              sram.sram_we_n   <= 1'b0;
              sram.sram_dq_oe  <= 1'b1;
              sram.sram_dq_out <= val_rm[15:0];
            end
          end
        end
        LOW: begin
          if (!last) begin
            cnt_q <= cnt_q + CW'(1);
          end else begin
            cnt_q          <= '0;
            sram.sram_addr <= {word, 1'b1};
            if (is_wr_q) sram.sram_dq_out <= val_rm[31:16];
            else         lo_buf_q         <= sram.sram_dq_in;
          end
        end
        HIGH: begin
          if (!last) begin
            cnt_q <= cnt_q + CW'(1);
          end else begin
            cnt_q           <= '0;
            sram.sram_we_n  <= 1'b1;
            sram.sram_dq_oe <= 1'b0;
            if (!is_wr_q) mem_result <= {sram.sram_dq_in, lo_buf_q};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Self-checking bench for mem_stage_sram: behavioural SRAM plus a word-level
// reference memory; directed scenarios followed by randomized loads/stores.
module tb_mem_stage_sram;
  localparam int W    = 2;
  localparam int AW   = 18;
  localparam int BASE = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [31:0] alu_result, val_rm;
  logic [3:0]  dest_in;
  logic        wb_en, mem_r_en, ready;
  logic [31:0] alu_result_out, mem_result;
  logic [3:0]  dest;

  mem_stage_sram_if #(.SRAM_AW(AW)) sif ();

  mem_stage_sram #(.WAIT_CYCLES(W), .BASE_ADDR(32'd1024), .SRAM_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .alu_result(alu_result), .val_rm(val_rm), .dest_in(dest_in),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .alu_result_out(alu_result_out),
    .dest(dest), .mem_result(mem_result), .ready(ready), .sram(sif)
  );

  always #5 clk = ~clk;

  // Behavioural async SRAM: reads are combinational, writes land while WE# is low.
  logic [15:0] sram_mem [0:(1<<AW)-1];
  logic [33:0] wr_log [$];
  int          cyc = 0;

  assign sif.sram_dq_in = sram_mem[sif.sram_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!sif.sram_we_n && sif.sram_dq_oe) begin
      sram_mem[sif.sram_addr] <= sif.sram_dq_out;
      if (wr_log.size() == 0 || wr_log[$] != {sif.sram_addr, sif.sram_dq_out})
        wr_log.push_back({sif.sram_addr, sif.sram_dq_out});
    end
  end

  // Reference: 32-bit words indexed by (addr - BASE) / 4, wrapped to the SRAM size.
  logic [31:0] ref_mem [int unsigned];
  int unsigned written [$];

  int errors = 0;
  int checks = 0;

  int          op_low, op_start_cyc, op_done_cyc;
  logic        op_ok, op_we_seen;
  logic [AW-1:0] op_lo_addr, op_hi_addr;

  function automatic int unsigned word_of(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return (o / 4) % (1 << (AW - 1));
  endfunction

  task automatic run_op(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] dst);
    @(negedge clk);
    mem_r_en_in = r; mem_w_en_in = w; wb_en_in = r;
    alu_result = a; val_rm = d; dest_in = dst;
    op_low = 0; op_ok = 1'b0; op_we_seen = 1'b0;
    op_lo_addr = '0; op_hi_addr = '0;
    op_start_cyc = cyc; op_done_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (ready) begin
        op_ok = 1'b1;
        op_done_cyc = cyc;
        break;
      end
      if (!sif.sram_we_n) op_we_seen = 1'b1;
      if (op_low == 1)     op_lo_addr = sif.sram_addr;
      if (op_low == 1 + W) op_hi_addr = sif.sram_addr;
      op_low++;
      @(negedge clk);
    end
    if (w && !r) ref_mem[word_of(a)] = d;
  endtask

  task automatic idle_inputs();
    mem_r_en_in = 1'b0; mem_w_en_in = 1'b0; wb_en_in = 1'b0;
  endtask

  task automatic check_timing(input string name);
    checks++;
    if (!op_ok) begin
      errors++; $display("FAIL %s_timeout: ready never returned high after %0d cycles", name, op_low);
    end
    checks++;
    if (op_low !== 1 + 2 * W) begin
      errors++; $display("FAIL %s_ready_low: got %0d cycles expected %0d", name, op_low, 1 + 2 * W);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_w_en_in = 1'b1; mem_r_en_in = 1'b0; wb_en_in = 1'b0;
    alu_result = 32'd1028; val_rm = 32'h12345678; dest_in = 4'd1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
    checks++; if (sif.sram_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n: got %b expected 1", sif.sram_we_n); end
    checks++; if (sif.sram_dq_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b expected 0", sif.sram_dq_oe); end
    checks++; if (mem_result !== 32'h0) begin errors++; $display("FAIL reset_mem_result: got %h expected 0", mem_result); end
    checks++; if (sif.sram_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 0", sif.sram_addr); end
    idle_inputs();
    @(negedge clk); rst = 1'b1;
    wr_log.delete();
  endtask

  task automatic test_store();
    run_op(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 4'd0);
    idle_inputs();
    check_timing("store");
    checks++;
    if (wr_log.size() != 2 || wr_log[0] != {18'd2, 16'hBEEF} || wr_log[1] != {18'd3, 16'hDEAD}) begin
      errors++;
      $display("FAIL store_sequence: got %0d writes first=%h last=%h expected 2 writes %h then %h",
               wr_log.size(), (wr_log.size() > 0) ? wr_log[0] : 34'h0,
               (wr_log.size() > 0) ? wr_log[$] : 34'h0, {18'd2, 16'hBEEF}, {18'd3, 16'hDEAD});
    end
    checks++; if (mem_result !== 32'h0) begin errors++; $display("FAIL store_keeps_result: got %h expected 0", mem_result); end
    written.push_back(word_of(32'd1028));
  endtask

  task automatic test_load();
    run_op(1'b1, 1'b0, 32'd1028, 32'h0, 4'd3);
    check_timing("load");
    checks++; if (mem_result !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data: got %h expected deadbeef", mem_result); end
    checks++; if (wb_en !== 1'b1 || dest !== 4'd3 || mem_r_en !== 1'b1) begin
      errors++; $display("FAIL load_passthru: got wb_en=%b dest=%0d mem_r_en=%b expected 1 3 1", wb_en, dest, mem_r_en); end
    checks++; if (op_lo_addr !== 18'd2 || op_hi_addr !== 18'd3) begin
      errors++; $display("FAIL load_addr: got %0d/%0d expected 2/3", op_lo_addr, op_hi_addr); end
    idle_inputs();
  endtask

  task automatic test_address_edges();
    logic [31:0] d;
    d = $urandom;
    run_op(1'b0, 1'b1, 32'd1031, d, 4'd0);
    idle_inputs();
    checks++; if (op_lo_addr !== 18'd2 || op_hi_addr !== 18'd3) begin
      errors++; $display("FAIL addr_1031: got %0d/%0d expected 2/3", op_lo_addr, op_hi_addr); end
    d = $urandom | 32'h1;
    run_op(1'b0, 1'b1, 32'd1024, d, 4'd0);
    idle_inputs();
    written.push_back(0);
    checks++; if (op_lo_addr !== 18'd0 || op_hi_addr !== 18'd1) begin
      errors++; $display("FAIL addr_1024: got %0d/%0d expected 0/1", op_lo_addr, op_hi_addr); end
    run_op(1'b1, 1'b1, 32'd1024, ~d, 4'd2);
    check_timing("both_en");
    checks++; if (op_we_seen !== 1'b0) begin errors++; $display("FAIL both_en_no_write: got we_n low seen=%b expected 0", op_we_seen); end
    checks++; if (mem_result !== ref_mem[0]) begin errors++; $display("FAIL both_en_read: got %h expected %h", mem_result, ref_mem[0]); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    mem_r_en_in = 1'b1; wb_en_in = 1'b1; alu_result = 32'd1028; dest_in = 4'd4;
    repeat (1 + W) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (ready !== 1'b1 || sif.sram_we_n !== 1'b1 || sif.sram_dq_oe !== 1'b0) begin
      errors++; $display("FAIL midrst_pins: got ready=%b we_n=%b oe=%b expected 1 1 0", ready, sif.sram_we_n, sif.sram_dq_oe); end
    checks++; if (mem_result !== 32'h0 || sif.sram_addr !== '0) begin
      errors++; $display("FAIL midrst_regs: got result=%h addr=%h expected 0 0", mem_result, sif.sram_addr); end
    idle_inputs();
    @(negedge clk); rst = 1'b1;
    run_op(1'b1, 1'b0, 32'd1028, 32'h0, 4'd4);
    check_timing("midrst_reload");
    checks++; if (mem_result !== ref_mem[word_of(32'd1028)]) begin
      errors++; $display("FAIL midrst_reload: got %h expected %h", mem_result, ref_mem[word_of(32'd1028)]); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int first_done;
    d = $urandom;
    run_op(1'b0, 1'b1, 32'd1032, d, 4'd0);
    first_done = op_done_cyc;
    check_timing("b2b_store");
    written.push_back(word_of(32'd1032));
    run_op(1'b1, 1'b0, 32'd1032, 32'h0, 4'd6);
    check_timing("b2b_load");
    checks++; if (op_start_cyc !== first_done + 1) begin
      errors++; $display("FAIL b2b_gap: got start cycle %0d expected %0d", op_start_cyc, first_done + 1); end
    checks++; if (mem_result !== d) begin errors++; $display("FAIL b2b_data: got %h expected %h", mem_result, d); end
    idle_inputs();
    @(negedge clk);
    wb_en_in = 1'b1; alu_result = 32'd7; dest_in = 4'd9;
    #1;
    checks++; if (ready !== 1'b1 || alu_result_out !== 32'd7 || dest !== 4'd9 || wb_en !== 1'b1) begin
      errors++; $display("FAIL add_passthru: got ready=%b alu=%0d dest=%0d wb=%b expected 1 7 9 1",
                         ready, alu_result_out, dest, wb_en); end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [31:0] a, d, exp_res;
    int unsigned wd;
    exp_res = mem_result;
    for (int n = 0; n < 24; n++) begin
      if (written.size() == 0 || $urandom_range(0, 1) == 0) begin
        a = BASE + ($urandom_range(0, 63) * 4) + $urandom_range(0, 3);
        d = $urandom;
        run_op(1'b0, 1'b1, a, d, 4'd0);
        written.push_back(word_of(a));
      end else begin
        wd = written[$urandom_range(0, written.size() - 1)];
        a = BASE + wd * 4 + $urandom_range(0, 3);
        run_op(1'b1, 1'b0, a, 32'h0, 4'($urandom));
        exp_res = ref_mem[wd];
      end
      check_timing("rand");
      wd = word_of(a);
      checks++; if (op_lo_addr !== AW'(wd * 2) || op_hi_addr !== AW'(wd * 2 + 1)) begin
        errors++; $display("FAIL rand_addr: a=%0d got %0d/%0d expected %0d/%0d", a, op_lo_addr, op_hi_addr, wd * 2, wd * 2 + 1); end
      checks++; if (mem_result !== exp_res) begin
        errors++; $display("FAIL rand_result: a=%0d got %h expected %h", a, mem_result, exp_res); end
      idle_inputs();
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 16'h0;
    test_reset();
    test_store();
    test_load();
    test_address_edges();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
